vga_text_writer: RTL and testbench
==================================

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameter COLS, default 70, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ch_valid  input  1  character offered.
REQ-006 SHALL have ch_data  input  8  ASCII code offered.
REQ-007 SHALL have ch_ready  output  1  writer can accept a character this cycle.
REQ-008 SHALL have wr_en  output  1  single-cycle text-memory write strobe.
REQ-009 SHALL have wr_addr  output  10  text-memory word address, equal to byte_addr[11:2].
REQ-010 SHALL have wr_data  output  32  written byte replicated in all four lanes.
REQ-011 SHALL have wr_be  output  4  one-hot byte enable; bit k set when byte_addr[1:0]=k, so lane k is data[8k+7:8k].
REQ-012 SHALL have cursor_row  output  5  current row, 0..ROWS-1.
REQ-013 SHALL have cursor_col  output  7  current column, 0..COLS-1.
REQ-014 SHALL have busy  output  1  a clear sequence is in progress.

Function
REQ-015 SHALL compute byte_addr = row*COLS + col in 12 bits; the maximum is 2099 for the defaults.
REQ-016 SHALL use the states CLEAR_ALL, IDLE and CLEAR_ROW.
REQ-017 SHALL drive ch_ready=1 only in IDLE; a character is accepted on a cycle with ch_valid & ch_ready.
REQ-018 SHALL, for an accepted character in cycle N, present any write in cycle N+1, with wr_en registered.
REQ-019 SHALL sustain a throughput of one accepted character per cycle while no clear is triggered.
REQ-020 SHALL, for printable codes 0x20..0x7E, write the code at the cursor, then set col+1.
REQ-021 SHALL, when col=COLS-1 for a printable code, set col=0 and row+1 instead.
REQ-022 SHALL, for 0x0D (CR), set col=0 without writing.
REQ-023 SHALL, for 0x0A (LF), set col=0 and row+1 without writing.
REQ-024 SHALL, for 0x08 (BS) with col>0, set col-1 and write 0x20 at the new cursor.
REQ-025 SHALL, for 0x08 (BS) with col=0, do nothing.
REQ-026 SHALL, for 0x0C (FF), set the cursor to (0,0) and enter CLEAR_ALL.
REQ-027 SHALL accept and discard all other codes, with no write and no cursor change.
REQ-028 SHALL, when a row increment occurs from row ROWS-1, set row to 0, set col to 0 and enter CLEAR_ROW for row 0.
REQ-029 SHALL, in CLEAR_ROW, write 0x20 to byte addresses row*COLS .. row*COLS+COLS-1, one byte per cycle, in ascending order.
REQ-030 SHALL start the CLEAR_ROW writes in the cycle after any character write belonging to the triggering character.
REQ-031 SHALL, in CLEAR_ALL, write 0x20 to byte addresses 0 .. ROWS*COLS-1, one byte per cycle, in ascending order.
REQ-032 SHALL drive ch_ready=0 and busy=1 from the cycle after the triggering accept until the cycle after the last clear write.
REQ-033 SHALL return to IDLE after a clear; ch_ready=1 in the following cycle.
REQ-034 SHALL ignore ch_valid while ch_ready=0; ch_data may change freely then.
REQ-035 SHALL drive cursor_row and cursor_col as registers, updated in the cycle after the accept.
REQ-036 SHALL make cursor_row and cursor_col show their final values during clears.
REQ-037 SHALL hold wr_addr, wr_data and wr_be at their last values when wr_en=0; they are don't-care to consumers.

Reset
REQ-038 SHALL, while reset=1, set wr_en=0, wr_addr=0, wr_data=0, wr_be=0, cursor_row=0, cursor_col=0 and ch_ready=0.
REQ-039 SHALL, while reset=1, set busy=1 and state=CLEAR_ALL with the clear counter at 0.
REQ-040 SHALL issue the first clear write (byte 0) in the first cycle after reset deasserts.
REQ-041 SHALL, on reset asserted mid-clear or mid-stream, abort immediately and restart the full clear after release.

Verification
REQ-042 SHALL cover: release reset -> 2100 consecutive wr_en pulses with data 0x20202020; the first has addr 0, be 0001 and the last has addr 524, be 1000; ch_ready=1 the next cycle.
REQ-043 SHALL cover: at (0,0) send 0x41 then 0x42 -> writes addr 0 be 0001 data 0x41414141, then addr 0 be 0010 data 0x42424242; cursor (0,2).
REQ-044 SHALL cover: at (0,5) send LF then 0x43 -> no write for LF; 0x43 written at byte 70 = addr 17 be 0100; cursor (1,1).
REQ-045 SHALL cover: at (29,69) send 0x5A -> write addr 524 be 1000; then 70 clear writes for bytes 0..69; ch_ready low for 71 cycles; cursor (0,0).
REQ-046 SHALL cover: at (3,5) send BS -> write 0x20 at byte 214 = addr 53 be 0100; cursor (3,4); at (0,0) send BS -> no write, cursor unchanged.
REQ-047 SHALL cover: assert reset during a CLEAR_ROW -> reset values of REQ-038/REQ-039 hold, and the full clear restarts from byte 0 after release.

Source files
------------

// File: rtl/vga_text_writer.sv
// Text-mode character writer: turns an ASCII stream into byte writes
// on a 32-bit text memory, tracking the cursor and clearing on wrap/FF.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   ch_valid/ch_data     offered character; ch_ready accepts it
//   wr_en/wr_addr        registered write strobe, word address
//   wr_data/wr_be        byte replicated to 4 lanes, one-hot lane
//   cursor_row/col       current cursor position
//   busy                 a clear sequence is running
module vga_text_writer #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [11:0] TOTAL    = 12'(ROWS * COLS);
  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  state_t      r_state;
  logic [11:0] r_clr;
  logic [4:0]  r_row;
  logic [6:0]  r_col;
  logic        r_wr_en;
  logic [9:0]  r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_be;
  logic        r_ready;
  logic        r_busy;

  logic [11:0] w_byte;
  logic [11:0] w_clr_end;
  logic        w_accept;
  logic        w_print;
  logic        w_col_last;
  logic        w_nl;
  logic        w_do;
  logic [11:0] w_wbyte;
  logic [7:0]  w_wchar;

  assign w_byte     = 12'(r_row) * COLS_W + 12'(r_col);
  assign w_clr_end  = (r_state == CLEAR_ALL) ? TOTAL : COLS_W;
  assign w_accept   = ch_valid & r_ready & (r_state == IDLE);
  assign w_print    = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
  assign w_col_last = (r_col == LAST_COL);
  // Line feed, or a printable character landing in the last column.
  assign w_nl       = (w_print && w_col_last) || (ch_data == 8'h0A);

  // Selects the byte to write this cycle, if any.
  always_comb begin
    w_do    = 1'b0;
    w_wbyte = 12'd0;
    w_wchar = 8'h00;
    if (r_state != IDLE) begin
      if (r_clr < w_clr_end) begin
        w_do    = 1'b1;
        w_wbyte = r_clr;
        w_wchar = 8'h20;
      end
    end else if (w_accept) begin
      if (w_print) begin
        w_do    = 1'b1;
        w_wbyte = w_byte;
        w_wchar = ch_data;
      end else if (ch_data == 8'h08 && r_col != 7'd0) begin
        w_do    = 1'b1;
        w_wbyte = w_byte - 12'd1;
        w_wchar = 8'h20;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR_ALL;
      r_clr   <= 12'd0;
      r_row   <= 5'd0;
      r_col   <= 7'd0;
      r_wr_en <= 1'b0;
      r_addr  <= 10'd0;
      r_data  <= 32'd0;
      r_be    <= 4'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_wr_en <= w_do;
      if (w_do) begin
        r_addr <= w_wbyte[11:2];
        r_be   <= 4'b0001 << w_wbyte[1:0];
        r_data <= {4{w_wchar}};
      end
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_print && !w_col_last)
              r_col <= r_col + 7'd1;
            if (ch_data == 8'h0D)
              r_col <= 7'd0;
            if (ch_data == 8'h08 && r_col != 7'd0)
              r_col <= r_col - 7'd1;
            if (w_nl) begin
              r_col <= 7'd0;
              if (r_row == LAST_ROW) begin
                r_row   <= 5'd0;
                r_clr   <= 12'd0;
                r_state <= CLEAR_ROW;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
              end else begin
                r_row <= r_row + 5'd1;
              end
            end
            if (ch_data == 8'h0C) begin
              r_row   <= 5'd0;
              r_col   <= 7'd0;
              r_clr   <= 12'd0;
              r_state <= CLEAR_ALL;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        CLEAR_ALL, CLEAR_ROW: begin
          // One extra cycle past the last write before ready rises.
          if (r_clr < w_clr_end) begin
            r_clr <= r_clr + 12'd1;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= CLEAR_ALL;
      endcase
    end
  end

  assign ch_ready   = r_ready;
  assign busy       = r_busy;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_addr;
  assign wr_data    = r_data;
  assign wr_be      = r_be;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: directed cases plus a
// random character stream checked against a queue-based screen model.
module tb_vga_text_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int row_m = 0;
  int col_m = 0;
  int wcount = 0;
  logic [19:0] exp_q[$];
  logic [9:0]  l_addr;
  logic [3:0]  l_be;
  logic [31:0] l_data;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({12'(i), 8'h20});
  endtask

  // Moves the model cursor down one line, wrapping to a row-0 clear.
  task automatic newline(output bit clr);
    clr = 1'b0;
    col_m = 0;
    if (row_m == ROWS - 1) begin
      row_m = 0;
      push_clear(COLS);
      clr = 1'b1;
    end else begin
      row_m++;
    end
  endtask

  task automatic model(input logic [7:0] c, output bit clr);
    clr = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back({12'(row_m * COLS + col_m), c});
      if (col_m == COLS - 1) newline(clr);
      else col_m++;
    end else if (c == 8'h0D) begin
      col_m = 0;
    end else if (c == 8'h0A) begin
      newline(clr);
    end else if (c == 8'h08) begin
      if (col_m > 0) begin
        col_m--;
        exp_q.push_back({12'(row_m * COLS + col_m), 8'h20});
      end
    end else if (c == 8'h0C) begin
      row_m = 0;
      col_m = 0;
      push_clear(TOTAL);
      clr = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [19:0] e;
      wcount++;
      l_addr = wr_addr;
      l_be   = wr_be;
      l_data = wr_data;
      if (exp_q.size() == 0) begin
        check("spurious_wr", {wr_addr, wr_be, wr_data}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("wr", {wr_addr, wr_be, wr_data},
              {e[19:10], 4'b0001 << e[9:8], {4{e[7:0]}}});
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!ch_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      check("ready_timeout", 64'd0, 64'd1);
      finish_run();
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    bit clr;
    ch_valid = 1'b1;
    ch_data  = c;
    wait_ready(n);
    @(posedge clk);
    model(c, clr);
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data  = 8'($urandom);
    #1;
    check("row", 64'(cursor_row), 64'(row_m));
    check("col", 64'(cursor_col), 64'(col_m));
    check("rdy", 64'(ch_ready), 64'(!clr));
    check("busy", 64'(busy), 64'(clr));
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_be", 64'(wr_be), 64'd0);
    check("rst_row", 64'(cursor_row), 64'd0);
    check("rst_col", 64'(cursor_col), 64'd0);
    check("rst_ready", 64'(ch_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    #900000;
    check("watchdog", 64'd0, 64'd1);
    finish_run();
  end

  initial begin
    int n;
    int w0;
    logic [7:0] c;
    reset    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();

    // Full clear after reset: 2100 writes, then ready.
    @(negedge clk);
    reset = 1'b0;
    push_clear(TOTAL);
    wait_ready(n);
    check("clr_all_len", 64'(n), 64'(TOTAL + 1));
    check("clr_all_q", 64'(exp_q.size()), 64'd0);

    send(8'h41);
    send(8'h42);
    check("ab_wr", {l_addr, l_be, l_data}, {10'd0, 4'b0010, 32'h42424242});

    send(8'h0D);
    repeat (5) send(8'h61);
    send(8'h0A);
    send(8'h43);
    check("lf_wr", {l_addr, l_be, l_data}, {10'd17, 4'b0100, 32'h43434343});

    send(8'h0A);
    send(8'h0A);
    repeat (5) send(8'h62);
    send(8'h08);
    check("bs_wr", {l_addr, l_be, l_data}, {10'd53, 4'b0100, 32'h20202020});

    send(8'h0C);
    wait_ready(n);
    w0 = wcount;
    send(8'h08);
    check("bs0_nowr", 64'(wcount), 64'(w0));

    // Walk to (29,69) and overflow the last cell.
    repeat (ROWS - 1) send(8'h0A);
    repeat (COLS - 1) send(8'h2E);
    send(8'h5A);
    check("wrap_wr", {l_addr, l_be, l_data}, {10'd524, 4'b1000, 32'h5A5A5A5A});
    n = 0;
    while (!ch_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("wrap_busy_len", 64'(n), 64'(COLS + 1));

    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 75)      c = 8'($urandom_range(32, 126));
      else if (r < 82) c = 8'h0D;
      else if (r < 90) c = 8'h0A;
      else if (r < 96) c = 8'h08;
      else if (r < 97) c = 8'h0C;
      else             c = 8'($urandom);
      send(c);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset in the middle of a row clear.
    send(8'h0D);
    while (row_m != ROWS - 1) send(8'h0A);
    send(8'h0A);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    row_m = 0;
    col_m = 0;
    @(negedge clk);
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_clear(TOTAL);
    wait_ready(n);
    check("clr_restart_len", 64'(n), 64'(TOTAL + 1));

    send(8'h41);
    check("post_wr", {l_addr, l_be, l_data}, {10'd0, 4'b0001, 32'h41414141});
    repeat (3) @(negedge clk);
    check("final_q", 64'(exp_q.size()), 64'd0);
    finish_run();
  end

endmodule
